interrupt_injector: RTL
=======================

# interrupt_injector

Fetch-stage sequencer that consumes the single-cycle `o_interrupt_call` pulse from the interrupt edge detector and turns it into an interrupt entry in the instruction stream. It waits for a safe fetch slot, replaces the fetched instruction with the INT opcode, freezes the PC, and captures the return address. It then issues a fixed number of NOP bubbles while the pipeline pushes state, and releases fetch. A single-deep pending latch absorbs calls that arrive while busy, stalled or flushing.

## Interface
- INSTR_WIDTH, 16, instruction word width
- PC_WIDTH, 32, program counter width
- INT_OPCODE, 16'hF800, injected interrupt-entry instruction
- NOP_OPCODE, 16'h0000, bubble instruction
- DRAIN_CYCLES, 2, bubble count after INT (legal range 1..15)

- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_interrupt_call  in  1  one-cycle request pulse from the edge detector
- i_stall  in  1  fetch stall; freezes the sequencer
- i_flush  in  1  control-hazard flush in progress; blocks starting an entry
- i_pc  in  PC_WIDTH  current fetch PC
- i_instruction  in  INSTR_WIDTH  word from instruction memory
- o_instruction  out  INSTR_WIDTH  word forwarded to the fetch/decode register
- o_inject  out  1  high while o_instruction is sequencer-generated
- o_pc_hold  out  1  high while the PC must not advance
- o_saved_pc  out  PC_WIDTH  return address of the last serviced interrupt
- o_busy  out  1  state != IDLE or request pending
- o_dropped  out  1  one-cycle pulse when a request is lost

## Operation
- States:
  - IDLE: pass-through. o_instruction = i_instruction, o_inject = 0, o_pc_hold = 0.
  - INJECT: o_instruction = INT_OPCODE, o_inject = 1, o_pc_hold = 1.
  - DRAIN: o_instruction = NOP_OPCODE, o_inject = 1, o_pc_hold = 1.
- Request = i_interrupt_call OR pending.
- IDLE -> INJECT at a rising edge where request = 1, i_stall = 0 and i_flush = 0.
  - pending is cleared on that edge.
  - If the request was blocked, set pending instead.
- INJECT -> DRAIN at the first edge with i_stall = 0.
  - On that edge: o_saved_pc <= i_pc (the PC is frozen, so this is the displaced, un-executed instruction).
  - Drain counter <= DRAIN_CYCLES - 1.
- DRAIN: on each edge with i_stall = 0, decrement the counter; at 0 go to IDLE.
- IDLE lasts at least one cycle between services. A set pending is serviced from IDLE under the normal start rule.
- i_interrupt_call arriving in INJECT, DRAIN, or while blocked in IDLE:
  - pending = 0: set pending.
  - pending = 1: request is discarded and o_dropped pulses on the next cycle.
- i_stall = 1: state, counter and o_saved_pc hold; o_instruction and o_inject hold their current values. Request latching still occurs.
- i_flush is checked only for the IDLE -> INJECT decision. It does not abort INJECT or DRAIN.
- o_instruction, o_inject and o_pc_hold are decoded combinationally from state. All state and counters are registered.

## Timing
- Reset values:
  - state = IDLE, pending = 0, counter = 0.
  - o_saved_pc = 0, o_dropped = 0, o_busy = 0, o_inject = 0, o_pc_hold = 0.
  - o_instruction = i_instruction.
- Reset has priority over every event. Mid-sequence reset returns to IDLE in one edge, pending is lost, o_saved_pc is cleared.
- Latency: call high in cycle t with no stall or flush:
  - cycle t+1: INJECT.
  - cycles t+2 .. t+1+DRAIN_CYCLES: DRAIN.
  - cycle t+2+DRAIN_CYCLES: IDLE.
  - o_saved_pc is valid from t+2.
- Back-to-back service: a second call arriving during the sequence re-enters INJECT exactly one IDLE cycle after DRAIN ends.
- Call coincident with reset is ignored.
- A call in the same cycle that pending is consumed sets pending again (no drop).

## Test plan
- Basic entry (defaults): i_pc = 0x40, call pulse at cycle 5, no stall.
  - Cycle 6: o_instruction = 0xF800, o_pc_hold = 1.
  - Cycles 7-8: 0x0000.
  - Cycle 9: pass-through.
  - o_saved_pc = 0x40 from cycle 7.
- Flush block: call while i_flush = 1 for 3 cycles.
  - pending = 1, o_busy = 1, no inject.
  - INJECT on the cycle after i_flush falls.
- Stall mid-drain: i_stall high for 4 cycles in the first DRAIN cycle.
  - Outputs frozen at 0x0000.
  - Total DRAIN non-stall cycles = 2.
  - o_saved_pc unchanged.
- Nested requests: second call in INJECT.
  - Serviced after one IDLE cycle; o_saved_pc updates to the new i_pc.
  - Third call while pending = 1: o_dropped pulses once; only two INT opcodes are emitted.
- Reset mid-sequence: i_reset in the first DRAIN cycle with pending = 1.
  - Next cycle: IDLE, all outputs at reset values.
  - No further INT is emitted.

Source files
------------

// File: rtl/interrupt_injector.sv
// interrupt_injector
// Fetch-stage sequencer that turns a one-cycle interrupt call into an
// interrupt entry in the instruction stream. In order it emits:
//   1. the INT opcode (the PC is frozen and the return address is captured),
//   2. DRAIN_CYCLES NOP bubbles,
//   3. then it releases fetch.
// A single-deep pending latch absorbs a call that arrives while the
// sequencer is busy or blocked. A call that arrives while that latch is
// already full is reported on o_dropped.

module interrupt_injector #(
  parameter int                     INSTR_WIDTH  = 16,
  parameter int                     PC_WIDTH     = 32,
  parameter logic [INSTR_WIDTH-1:0] INT_OPCODE   = 16'hF800,
  parameter logic [INSTR_WIDTH-1:0] NOP_OPCODE   = 16'h0000,
  parameter int                     DRAIN_CYCLES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_interrupt_call,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic [PC_WIDTH-1:0]    i_pc,
  input  logic [INSTR_WIDTH-1:0] i_instruction,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic                   o_inject,
  output logic                   o_pc_hold,
  output logic [PC_WIDTH-1:0]    o_saved_pc,
  output logic                   o_busy,
  output logic                   o_dropped
);

  // Four bits cover the full 1..15 bubble range.
  localparam int               CNT_W      = 4;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_INJECT = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  logic [1:0]          state_reg;
  logic [1:0]          state_next;
  logic [CNT_W-1:0]    count_reg;
  logic [CNT_W-1:0]    count_next;
  logic                pending_reg;
  logic                pending_next;
  logic [PC_WIDTH-1:0] saved_pc_reg;
  logic [PC_WIDTH-1:0] saved_pc_next;
  logic                dropped_reg;
  logic                dropped_next;

  logic                request;
  logic                start;
  logic                sel_pass;
  logic                sel_int;

  // A request is either a fresh call or one parked in the pending latch.
  // Entry may only begin from IDLE, and only when neither a stall nor a
  // flush is in progress.
  always_comb begin
    request = i_interrupt_call | pending_reg;
    start   = (state_reg == ST_IDLE) & request & ~i_stall & ~i_flush;
  end

  // Sequencer next state: the return address and the bubble count are
  // loaded on the edge that leaves INJECT. A stall freezes every state
  // element below.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    saved_pc_next = saved_pc_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_INJECT;
        end
      end
      ST_INJECT: begin
        if (!i_stall) begin
          state_next    = ST_DRAIN;
          count_next    = DRAIN_LOAD;
          saved_pc_next = i_pc;
        end
      end
      ST_DRAIN: begin
        if (!i_stall) begin
          if (count_reg == '0) begin
            state_next = ST_IDLE;
          end else begin
            count_next = count_reg - 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  // Pending latch and drop detection. Starting an entry consumes the
  // pending request. A call on that same edge re-arms the latch, which
  // is not a drop. Any other call either fills an empty latch or is
  // discarded and reported as a drop.
  always_comb begin
    pending_next = pending_reg;
    dropped_next = 1'b0;
    if (start) begin
      pending_next = pending_reg & i_interrupt_call;
    end else if (i_interrupt_call) begin
      if (pending_reg) begin
        dropped_next = 1'b1;
      end else begin
        pending_next = 1'b1;
      end
    end
  end

  // State registers. Reset wins over every other event, including a
  // coincident call.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      pending_reg  <= 1'b0;
      saved_pc_reg <= '0;
      dropped_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      pending_reg  <= pending_next;
      saved_pc_reg <= saved_pc_next;
      dropped_reg  <= dropped_next;
    end
  end

  // Output select lines are decoded from the registered state only. As a
  // result they hold naturally while the state is frozen by a stall.
  always_comb begin
    sel_pass = (state_reg != ST_INJECT) && (state_reg != ST_DRAIN);
    sel_int  = (state_reg == ST_INJECT);
  end

  // Per-bit three-way select:
  //   - IDLE   -> memory word,
  //   - INJECT -> INT opcode,
  //   - DRAIN  -> NOP opcode.
  for (genvar gi = 0; gi < INSTR_WIDTH; gi++) begin : g_instr_mux
    assign o_instruction[gi] = sel_pass ? i_instruction[gi] :
                               sel_int  ? INT_OPCODE[gi]    :
                                          NOP_OPCODE[gi];
  end

  assign o_inject   = ~sel_pass;
  assign o_pc_hold  = ~sel_pass;
  assign o_saved_pc = saved_pc_reg;
  assign o_busy     = (state_reg != ST_IDLE) | pending_reg;
  assign o_dropped  = dropped_reg;

endmodule
